mig_tt_evaluator: RTL and testbench
===================================

Name: mig_tt_evaluator

Overview:
- Sequential evaluator for majority-inverter-graph (MIG) netlists of 4-input functions; the reading end of the exact-synthesis flow.
- Accepts a stream of majority-gate descriptors, followed by one output descriptor.
- Simulates the netlist bit-parallel over all 16 input minterms and returns the 16-bit truth table.
- Sits behind the netlist loader; the checker uses it to compare synthesized MIGs against target NPN-class functions.

Parameters:
- MAX_GATES, 8, maximum number of majority gates per netlist.
- SEL_W, 4, node-select width; 2**SEL_W >= 5+MAX_GATES is required (checked at elaboration).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  descriptor beat valid.
- in_ready  out  1  evaluator accepts a beat.
- in_last  in  1  beat is the output descriptor; only sel_a/inv_a are used.
- in_sel_a, in_sel_b, in_sel_c  in  SEL_W each  operand node indices.
- in_inv_a, in_inv_b, in_inv_c  in  1 each  operand complement flags.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- out_tt  out  16  truth table; bit m = f(x3 x2 x1 x0 = m).
- out_err  out  1  netlist was malformed; out_tt forced to 0.

Behaviour:
- Node table (read-only ROM):
  - node 0 = 0x0000 (const0), node 1 = x0 = 0xAAAA, node 2 = x1 = 0xCCCC, node 3 = x2 = 0xF0F0, node 4 = x3 = 0xFF00.
  - node 5+k = gate k, stored in a register file of MAX_GATES x 16 bits.
- Operand value = node_tt[sel] XOR {16{inv}}.
- Gate result = bitwise MAJ(a,b,c) = (a&b)|(a&c)|(b&c).
- States:
  - LOAD: in_ready=1. On handshake with in_last=0, write gate[gcnt] in the same edge, then gcnt++.
  - LOAD, handshake with in_last=1: register out_tt = operand_a value (or 0 if err), go to DONE.
  - DONE: in_ready=0, out_valid=1. out_tt and out_err are held stable until out_valid&&out_ready. On that handshake: clear gcnt and err, go to LOAD.
- Latency: out_valid is high the cycle after the last beat is accepted. With back-to-back beats, one gate is evaluated per cycle.
- Zero-gate netlist (first beat has in_last=1) is legal; the result is a literal or constant.
- Error conditions (sticky err flag):
  - Any used sel >= 5+gcnt at accept time (forward/self reference or out of range).
  - A gate beat arriving when gcnt == MAX_GATES; that beat is not written.
- After an error, beats are still accepted until in_last. Then out_err=1 and out_tt=0x0000.
- in_valid low in LOAD: no state change. Input fields are don't-care when in_valid=0.
- Reset (async, any state): state=LOAD, gcnt=0, err=0, out_valid=0, out_tt=0, out_err=0. in_ready reads 1 from the first clock edge after reset deassertion (combinational from state). A partially loaded netlist is discarded; gate register contents need not be cleared.

Test Plan:
- Single beat in_last=1, sel_a=3, inv_a=1 -> out_valid next cycle, out_tt=0x0F0F, out_err=0.
- Gate0 = MAJ(x0,x1,const0) with no inversions, then output sel=5 -> 0x8888. Repeat with inv_c=1 -> 0xEEEE.
- Gate0 = MAJ(~x0,x1,x3), i.e. sel 1,2,4 with inv_a=1, then output sel=5 inv=1 -> out_tt=0x22BB (non-inverted gives 0xDD44).
- Gate0 with sel_b=5 (self reference), then output -> out_err=1, out_tt=0x0000. The next netlist evaluates cleanly with err cleared.
- MAX_GATES+1 gate beats, then output -> out_err=1. Separately, hold out_ready=0 for 3 cycles in DONE -> out_valid and out_tt stable, in_ready=0.
- Assert rst after 2 of 3 gates are accepted -> outputs zero immediately. The fresh netlist MAJ(x1,x2,x3) + output sel=5 -> 0xFCC0.

Source files
------------

// File: rtl/mig_tt_evaluator.sv
// mig_tt_evaluator: bit-parallel evaluation of a streamed 4-input MIG netlist into a 16-bit truth table
module mig_tt_evaluator #(
  parameter int MAX_GATES = 8,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [SEL_W-1:0] in_sel_a,
  input  logic [SEL_W-1:0] in_sel_b,
  input  logic [SEL_W-1:0] in_sel_c,
  input  logic             in_inv_a,
  input  logic             in_inv_b,
  input  logic             in_inv_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_tt,
  output logic             out_err
);
  localparam int CW = $clog2(MAX_GATES + 1);
  localparam int GW = (MAX_GATES > 1) ? $clog2(MAX_GATES) : 1;
  localparam int NN = 2 ** SEL_W;
  typedef enum logic {LOAD, DONE} state_t;
  generate
    if (NN < 5 + MAX_GATES) begin : g_sel_check
      $error("SEL_W too narrow for MAX_GATES");
    end
  endgenerate
  state_t state, state_nx;
  logic [CW-1:0] gcnt;
  logic err, acc, full, bad_a, bad_b, bad_c, new_err, err_nx, gate_wr;
  logic [15:0] gates [MAX_GATES];
  logic [15:0] nodes [NN];
  logic [15:0] opa, opb, opc;
  // node table: constant, the four input literals, then the gate register file
  always_comb begin
    for (int i = 0; i < NN; i++) nodes[i] = 16'h0000;
    nodes[1] = 16'hAAAA;
    nodes[2] = 16'hCCCC;
    nodes[3] = 16'hF0F0;
    nodes[4] = 16'hFF00;
    for (int k = 0; k < MAX_GATES; k++) nodes[k + 5] = gates[k];
  end
  // operand fetch, legality checks and next-state decode
  always_comb begin
    opa = nodes[in_sel_a] ^ {16{in_inv_a}};
    opb = nodes[in_sel_b] ^ {16{in_inv_b}};
    opc = nodes[in_sel_c] ^ {16{in_inv_c}};
    acc = in_valid && state == LOAD;
    full = gcnt == CW'(MAX_GATES);
    bad_a = 32'(in_sel_a) >= 32'(gcnt) + 32'd5;
    bad_b = 32'(in_sel_b) >= 32'(gcnt) + 32'd5;
    bad_c = 32'(in_sel_c) >= 32'(gcnt) + 32'd5;
    new_err = acc && (bad_a || (!in_last && (bad_b || bad_c || full)));
    err_nx = err || new_err;
    gate_wr = acc && !in_last && !full;
    state_nx = state;
    if (acc && in_last) state_nx = DONE;
    else if (state == DONE && out_ready) state_nx = LOAD;
  end
  assign in_ready = state == LOAD;
  assign out_valid = state == DONE;
  // control state, gate counter, sticky error and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD;
      gcnt <= '0;
      err <= 1'b0;
      out_tt <= 16'h0000;
      out_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (acc && in_last) begin
        out_tt <= err_nx ? 16'h0000 : opa;
        out_err <= err_nx;
        err <= err_nx;
      end else if (state == DONE && out_ready) begin
        gcnt <= '0;
        err <= 1'b0;
      end else begin
        err <= err_nx;
        if (gate_wr) gcnt <= gcnt + 1'b1;
      end
    end
  end
  // gate evaluation: one bitwise majority per accepted gate beat
  always_ff @(posedge clk) begin
    if (gate_wr) gates[gcnt[GW-1:0]] <= (opa & opb) | (opa & opc) | (opb & opc);
  end
endmodule

// File: tb/tb_mig_tt_evaluator.sv
// tb_mig_tt_evaluator: directed checks of the MIG truth-table evaluator
module tb_mig_tt_evaluator;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_last = 0, in_inv_a = 0, in_inv_b = 0, in_inv_c = 0;
  logic [3:0] in_sel_a = 0, in_sel_b = 0, in_sel_c = 0;
  logic in_ready, out_valid, out_ready = 0, out_err;
  logic [15:0] out_tt;
  int tests = 0, fails = 0;

  mig_tt_evaluator #(.MAX_GATES(8), .SEL_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_sel_a(in_sel_a), .in_sel_b(in_sel_b), .in_sel_c(in_sel_c),
    .in_inv_a(in_inv_a), .in_inv_b(in_inv_b), .in_inv_c(in_inv_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_tt(out_tt), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic beat(input logic last, input logic [3:0] sa, input logic ia,
                      input logic [3:0] sb, input logic ib, input logic [3:0] sc, input logic ic);
    in_last = last; in_sel_a = sa; in_inv_a = ia; in_sel_b = sb; in_inv_b = ib;
    in_sel_c = sc; in_inv_c = ic; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0; in_sel_a = 4'hF; in_sel_b = 4'hF; in_sel_c = 4'hF;
  endtask

  task automatic take();
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1; #12;
    tests++; if (out_valid !== 0 || out_tt !== 16'h0 || out_err !== 0) begin fails++; $display("FAIL reset_outputs: valid=%b tt=%h err=%b, want 0/0000/0", out_valid, out_tt, out_err); end
    rst = 0;
    @(posedge clk); #1;
    tests++; if (in_ready !== 1) begin fails++; $display("FAIL reset_ready: in_ready=%b want 1", in_ready); end
  endtask

  task automatic test_literal();
    beat(1, 3, 1, 0, 0, 0, 0);
    tests++; if (out_valid !== 1 || out_tt !== 16'h0F0F || out_err !== 0) begin fails++; $display("FAIL literal: valid=%b tt=%h err=%b, want 1/0f0f/0", out_valid, out_tt, out_err); end
    tests++; if (in_ready !== 0) begin fails++; $display("FAIL literal_ready: in_ready=%b want 0", in_ready); end
    take();
    tests++; if (out_valid !== 0 || in_ready !== 1) begin fails++; $display("FAIL literal_release: valid=%b ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_and_or();
    beat(0, 1, 0, 2, 0, 0, 0);
    beat(1, 5, 0, 0, 0, 0, 0);
    tests++; if (out_valid !== 1 || out_tt !== 16'h8888 || out_err !== 0) begin fails++; $display("FAIL and_gate: valid=%b tt=%h err=%b, want 1/8888/0", out_valid, out_tt, out_err); end
    take();
    beat(0, 1, 0, 2, 0, 0, 1);
    beat(1, 5, 0, 0, 0, 0, 0);
    tests++; if (out_valid !== 1 || out_tt !== 16'hEEEE || out_err !== 0) begin fails++; $display("FAIL or_gate: valid=%b tt=%h err=%b, want 1/eeee/0", out_valid, out_tt, out_err); end
    take();
  endtask

  task automatic test_inverted();
    beat(0, 1, 1, 2, 0, 4, 0);
    beat(1, 5, 1, 0, 0, 0, 0);
    tests++; if (out_tt !== 16'h22BB || out_err !== 0) begin fails++; $display("FAIL inv_out: tt=%h err=%b, want 22bb/0", out_tt, out_err); end
    take();
    beat(0, 1, 1, 2, 0, 4, 0);
    beat(1, 5, 0, 0, 0, 0, 0);
    tests++; if (out_tt !== 16'hDD44 || out_err !== 0) begin fails++; $display("FAIL noninv_out: tt=%h err=%b, want dd44/0", out_tt, out_err); end
    take();
  endtask

  task automatic test_chain();
    beat(0, 1, 0, 2, 0, 0, 0);
    beat(0, 5, 0, 3, 0, 0, 1);
    beat(0, 6, 1, 4, 0, 0, 0);
    beat(1, 7, 0, 0, 0, 0, 0);
    tests++; if (out_tt !== 16'h0700 || out_err !== 0) begin fails++; $display("FAIL chain: tt=%h err=%b, want 0700/0", out_tt, out_err); end
    take();
  endtask

  task automatic test_self_ref();
    beat(0, 1, 0, 5, 0, 2, 0);
    beat(1, 5, 0, 0, 0, 0, 0);
    tests++; if (out_valid !== 1 || out_tt !== 16'h0000 || out_err !== 1) begin fails++; $display("FAIL self_ref: valid=%b tt=%h err=%b, want 1/0000/1", out_valid, out_tt, out_err); end
    take();
    beat(0, 1, 0, 2, 0, 0, 0);
    beat(1, 5, 0, 0, 0, 0, 0);
    tests++; if (out_tt !== 16'h8888 || out_err !== 0) begin fails++; $display("FAIL err_cleared: tt=%h err=%b, want 8888/0", out_tt, out_err); end
    take();
    beat(1, 5, 0, 0, 0, 0, 0);
    tests++; if (out_tt !== 16'h0000 || out_err !== 1) begin fails++; $display("FAIL out_fwd_ref: tt=%h err=%b, want 0000/1", out_tt, out_err); end
    take();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 9; i++) beat(0, 1, 0, 2, 0, 3, 0);
    beat(1, 5, 0, 0, 0, 0, 0);
    tests++; if (out_tt !== 16'h0000 || out_err !== 1) begin fails++; $display("FAIL overflow: tt=%h err=%b, want 0000/1", out_tt, out_err); end
    take();
    for (int i = 0; i < 8; i++) beat(0, 1, 0, 2, 0, 3, 0);
    beat(1, 12, 0, 0, 0, 0, 0);
    tests++; if (out_tt !== 16'hE8E8 || out_err !== 0) begin fails++; $display("FAIL full_ok: tt=%h err=%b, want e8e8/0", out_tt, out_err); end
    take();
  endtask

  task automatic test_hold();
    beat(1, 4, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_last = 1; in_sel_a = 1;
      @(posedge clk); #1;
      tests++; if (out_valid !== 1 || out_tt !== 16'hFF00 || out_err !== 0 || in_ready !== 0) begin fails++; $display("FAIL hold_%0d: valid=%b tt=%h err=%b ready=%b, want 1/ff00/0/0", i, out_valid, out_tt, out_err, in_ready); end
    end
    in_valid = 0;
    take();
    tests++; if (out_valid !== 0 || in_ready !== 1) begin fails++; $display("FAIL hold_release: valid=%b ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_mid_reset();
    beat(0, 1, 0, 2, 0, 3, 0);
    beat(0, 1, 1, 2, 1, 3, 1);
    #2 rst = 1; #1;
    tests++; if (out_valid !== 0 || out_tt !== 16'h0 || out_err !== 0) begin fails++; $display("FAIL mid_reset: valid=%b tt=%h err=%b, want 0/0000/0", out_valid, out_tt, out_err); end
    @(posedge clk); #3 rst = 0;
    @(posedge clk); #1;
    tests++; if (in_ready !== 1) begin fails++; $display("FAIL mid_reset_ready: in_ready=%b want 1", in_ready); end
    beat(0, 2, 0, 3, 0, 4, 0);
    beat(1, 5, 0, 0, 0, 0, 0);
    tests++; if (out_tt !== 16'hFCC0 || out_err !== 0) begin fails++; $display("FAIL after_reset: tt=%h err=%b, want fcc0/0", out_tt, out_err); end
    take();
  endtask

  task automatic test_done_reset();
    beat(1, 2, 0, 0, 0, 0, 0);
    #2 rst = 1; #1;
    tests++; if (out_valid !== 0 || out_tt !== 16'h0 || in_ready !== 1) begin fails++; $display("FAIL done_reset: valid=%b tt=%h ready=%b, want 0/0000/1", out_valid, out_tt, in_ready); end
    @(posedge clk); #3 rst = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_literal();
    test_and_or();
    test_inverted();
    test_chain();
    test_self_ref();
    test_overflow();
    test_hold();
    test_mid_reset();
    test_done_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
